// File: rtl/nibble_add_pkg.sv
// Shared types, constants and the ripple-add helper for the nibble-serial adder.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry_out, sum} of x + y + c, rippled bit by bit.
  function automatic logic [NIBBLE_W:0] ripple_add(input logic [NIBBLE_W-1:0] x,
                                                   input logic [NIBBLE_W-1:0] y,
                                                   input logic c);
    logic [NIBBLE_W-1:0] sm;
    logic                cc;
    cc = c;
    sm = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sm[i] = x[i] ^ y[i] ^ cc;
      cc    = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    return {cc, sm};
  endfunction

endpackage

// File: rtl/nibble_add_seq_csa.sv
// Combinational 4-bit carry-select adder: both carry-in cases are
// precomputed by ripple chains, and the real carry-in picks one.
module nibble_csa
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] res [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign res[gi] = ripple_add(x, y, gi[0]);
    end
  endgenerate

  assign {cout, sum} = cin ? res[1] : res[0];

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one nibble per cycle through a carry-select adder.
// Optional ovf output enabled by defining NIBBLE_ADD_OVF_EN.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  input  logic                    cin,
  output logic [4*NIBBLES-1:0]    s,
  output logic                    cout,
`ifdef NIBBLE_ADD_OVF_EN
  output logic                    ovf,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                carry_reg;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        s_reg;
  logic                cout_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] sum_nib;
  logic                csa_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  nibble_csa u_csa (
    .x    (a_nib[idx_reg]),
    .y    (b_nib[idx_reg]),
    .cin  (carry_reg),
    .sum  (sum_nib),
    .cout (csa_cout)
  );

`ifdef NIBBLE_ADD_OVF_EN
  logic ovf_reg;
  logic ovf_pend_reg;
  // Carry into the MSB is recovered as a^b^sum at that bit.
  logic msb_carry;
  assign msb_carry = a_nib[idx_reg][NIBBLE_W-1] ^ b_nib[idx_reg][NIBBLE_W-1]
                   ^ sum_nib[NIBBLE_W-1];
  assign ovf = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg      <= 1'b0;
      ovf_pend_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      ovf_pend_reg <= msb_carry ^ csa_cout;
    end else if (state_reg == DONE) begin
      ovf_reg      <= ovf_pend_reg;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            s_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) s_reg[i*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          end
          carry_reg <= csa_cout;
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          cout_reg  <= carry_reg;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s    = s_reg;
  assign cout = cout_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed self-checking bench for nibble_add_seq (NIBBLES=4); ovf checks
// are compiled in when NIBBLE_ADD_OVF_EN is defined.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] s;
  logic        cout;
  logic        busy;
  logic        done;
`ifdef NIBBLE_ADD_OVF_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout),
`ifdef NIBBLE_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits (bounded) for done; reports what was seen.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output int edges, output int busy_cycles);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
    if (!done) edges = 99;
    $display("op a=%h b=%h cin=%0d -> s=%h cout=%0d edges=%0d busy=%0d",
             av, bv, cv, s, cout, edges, busy_cycles);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, cout, s} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%0d done=%0d cout=%0d s=%h required all 0", busy, done, cout, s);
    end
    $display("reset: busy=%0d done=%0d s=%h cout=%0d", busy, done, s, cout);
  endtask

  task automatic test_basic;
    int e, bc;
    run_op(16'h000C, 16'h0001, 1'b0, e, bc);
    n_cmp++;
    if (s !== 16'h000D || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_sum: s=%h cout=%0d required s=000d cout=0", s, cout);
    end
    n_cmp++;
    if (e !== 6) begin
      n_bad++;
      $display("FAIL basic_latency: edges=%0d required 6", e);
    end
    n_cmp++;
    if (bc !== 5) begin
      n_bad++;
      $display("FAIL basic_busy: busy cycles=%0d required 5", bc);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (s !== 16'h000D || cout !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_after_done: s=%h cout=%0d done=%0d busy=%0d required 000d/0/0/0",
               s, cout, done, busy);
    end
  endtask

  task automatic test_carry_ripple;
    int e, bc;
    run_op(16'hFFFF, 16'h0001, 1'b0, e, bc);
    n_cmp++;
    if (s !== 16'h0000 || cout !== 1'b1) begin
      n_bad++;
      $display("FAIL carry_ripple: s=%h cout=%0d required s=0000 cout=1", s, cout);
    end
`ifdef NIBBLE_ADD_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: ovf=%0d required 0", ovf);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int e, bc;
    tick();
    run_op(16'h1234, 16'h4321, 1'b1, e, bc);
    n_cmp++;
    if (s !== 16'h5556 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: s=%h cout=%0d required s=5556 cout=0", s, cout);
    end
    // Start issued in the very cycle done is high (first IDLE cycle).
    run_op(16'h000F, 16'h0001, 1'b1, e, bc);
    n_cmp++;
    if (s !== 16'h0011 || cout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: s=%h cout=%0d required s=0011 cout=0", s, cout);
    end
    n_cmp++;
    if (e !== 6) begin
      n_bad++;
      $display("FAIL b2b_latency: edges=%0d required 6", e);
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    tick();
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        dones++;
        n_cmp++;
        if (s !== 16'h3333 || cout !== 1'b0) begin
          n_bad++;
          $display("FAIL ignore_result: s=%h cout=%0d required s=3333 cout=0", s, cout);
        end
      end
      tick();
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL ignore_done_count: done pulses=%0d required 1", dones);
    end
    $display("ignore_start: s=%h done pulses=%0d", s, dones);
  endtask

  task automatic test_reset_abort;
    int e, bc, dones;
    a = 16'h00F0; b = 16'h0F10; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || s !== 16'h0000 || cout !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: busy=%0d s=%h cout=%0d done=%0d required 0/0000/0/0",
               busy, s, cout, done);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dones++;
      tick();
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: done/busy cycles=%0d required 0", dones);
    end
    run_op(16'h0002, 16'h0003, 1'b0, e, bc);
    n_cmp++;
    if (s !== 16'h0005 || cout !== 1'b0 || e !== 6) begin
      n_bad++;
      $display("FAIL abort_recover: s=%h cout=%0d edges=%0d required 0005/0/6", s, cout, e);
    end
  endtask

`ifdef NIBBLE_ADD_OVF_EN
  task automatic test_ovf;
    int e, bc;
    tick();
    run_op(16'h7FFF, 16'h0001, 1'b0, e, bc);
    n_cmp++;
    if (s !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: s=%h cout=%0d ovf=%0d required 8000/0/1", s, cout, ovf);
    end
    tick();
    run_op(16'hFFFF, 16'h0001, 1'b0, e, bc);
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_none: ovf=%0d required 0", ovf);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
`ifdef NIBBLE_ADD_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, an operation request, sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, W each, the operands, captured on an accepted start.
REQ-006 The block SHALL have port cin, input, 1, the carry-in, captured on an accepted start.
REQ-007 The block SHALL have port s, output, W, the sum result.
REQ-008 The block SHALL have port cout, output, 1, the final carry-out.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress (RUN or DONE).
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking s/cout valid.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch a, b and cin, clear nibble index idx to 0, clear s, and go to RUN.
REQ-013 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-014 In RUN, the block SHALL each cycle add nibble idx of the latched a and b plus the carry register through one 4-bit carry-select adder, write the result into s[4*idx+3:4*idx], and update the carry register.
REQ-015 In RUN, the block SHALL go to DONE when idx = NIBBLES-1, and otherwise increment idx.
REQ-016 In DONE, the block SHALL drive done=1 and cout=final carry for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be NIBBLES+1 cycles: with start accepted at edge T, done is high in the cycle after edge T+NIBBLES+1 (6 edges total for NIBBLES=4).
REQ-018 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-019 A start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back operations.
REQ-020 s and cout SHALL hold their values after DONE until the next accepted start.
REQ-021 Arithmetic SHALL be unsigned modulo 2^W, with {cout,s} = a+b+cin exactly.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL force state=IDLE, idx=0, carry=0, s=0, cout=0, busy=0 and done=0; this has priority over start.
REQ-023 Reset during RUN or DONE SHALL abort the operation without asserting done.

Configuration
REQ-024 With NIBBLE_ADD_OVF_EN defined, the block SHALL add output port ovf (1 bit), set in DONE to the signed two's-complement overflow (carry into MSB XOR carry out of MSB), held like cout and reset to 0.
REQ-025 Without NIBBLE_ADD_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package nibble_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the constant NIBBLE_W=4.
REQ-027 The 4-bit carry-select adder SHALL be a separate sub-module, nibble_csa: purely combinational, with two ripple halves selected by the incoming carry.
REQ-028 The FSM, idx counter and carry register SHALL reside in nibble_add_seq.

Verification
REQ-029 Test: a=0x000C, b=0x0001, cin=0 -> s=0x000D, cout=0, done exactly 6 edges after start, busy high for 5 cycles.
REQ-030 Test: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1 (carry ripples through all 4 nibbles).
REQ-031 Test: a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0; then back-to-back start a=0x000F, b=0x0001, cin=1 -> s=0x0011.
REQ-032 Test: start pulsed again 2 cycles into an operation with different operands -> ignored; the original result is delivered and only one done pulse occurs.
REQ-033 Test: rst asserted during RUN -> next cycle busy=0, s=0, cout=0, no done pulse; a new start afterwards completes normally.
REQ-034 Test (NIBBLE_ADD_OVF_EN defined): a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; a=0xFFFF, b=0x0001 -> ovf=0.
